// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
//
// Oversampling UART receiver running entirely in the sysclk domain. Bit timing
// comes from a one-cycle baud tick (OVERSAMPLING ticks per bit). Each bit is
// decided by a 3-sample majority vote around the bit centre. Completed words
// are presented on a valid/ready holder with per-word parity and framing flags.
// A frame that completes while an unaccepted word is held is dropped, and
// overrun_err_out pulses for one cycle.
//
// Ports
//   sysclk_in        system clock (only clock)
//   rst_in           asynchronous active-high reset
//   baud_tick_in     one-cycle pulse, OVERSAMPLING pulses per bit period
//   rx_serial_in     raw serial line (idles high), synchronised internally
//   rx_data_out      received word, stable while rx_valid_out = 1
//   rx_valid_out     word available
//   rx_ready_in      consumer accepts the word when valid & ready
//   parity_err_out   parity mismatch on the presented word
//   frame_err_out    a stop bit of the presented word was sampled low
//   overrun_err_out  one-cycle pulse when a completed frame is dropped
//   busy_out         high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os #(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sysclk_in,
    input  logic                 rst_in,
    input  logic                 baud_tick_in,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    input  logic                 rx_ready_in,
    output logic                 parity_err_out,
    output logic                 frame_err_out,
    output logic                 overrun_err_out,
    output logic                 busy_out
);

    localparam int CW  = $clog2(OVERSAMPLING);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = OVERSAMPLING / 2;

    // Sample points: counts MID-1 and MID are stored, MID+1 is the decision.
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
    localparam logic          PAR_EN   = (PARITY_EN != 0);
    localparam logic          ONE_STOP = (STOP_BITS == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state_reg;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser, preset to the idle level so reset never looks
    // like a start bit.
    // -------------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       rxs;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge sysclk_in or posedge rst_in) begin
                    if (rst_in) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= rx_serial_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge sysclk_in or posedge rst_in) begin
                    if (rst_in) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign rxs = sync_reg[1];

    // -------------------------------------------------------------------------
    // Tick counter. Held at zero while idle, so the start-detect tick clears
    // it; afterwards it free-runs through every wrap until the frame ends,
    // keeping later bit centres aligned to the start edge.
    // -------------------------------------------------------------------------
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            cnt_reg <= '0;
        end else if (baud_tick_in) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Majority vote: two stored samples plus the live sample at the decision.
    // -------------------------------------------------------------------------
    logic samp0_reg;
    logic samp1_reg;
    logic dec_tick;
    logic vote;

    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            samp0_reg <= 1'b1;
            samp1_reg <= 1'b1;
        end else if (baud_tick_in) begin
            if (cnt_reg == CNT_S0) begin
                samp0_reg <= rxs;
            end
            if (cnt_reg == CNT_S1) begin
                samp1_reg <= rxs;
            end
        end
    end

    assign dec_tick = baud_tick_in && (state_reg != ST_IDLE) && (cnt_reg == CNT_DEC);
    assign vote     = (samp0_reg & samp1_reg) | (samp0_reg & rxs) | (samp1_reg & rxs);

    // -------------------------------------------------------------------------
    // Frame bookkeeping registers
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [BW-1:0]        bit_idx_reg;
    logic                 stop_idx_reg;
    logic                 par_flag_reg;
    logic                 frame_flag_reg;
    logic                 stop_last;
    logic                 par_expected;

    // Right-shift: each new bit enters at the MSB, so after DATA_BITS shifts
    // the first (LSB) bit received has reached bit 0.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_top
                assign shift_next[gi] = vote;
            end else begin : g_low
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign stop_last    = ONE_STOP || stop_idx_reg;
    assign par_expected = (^shift_reg) ^ PAR_ODD;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. Nothing advances without a baud tick.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (baud_tick_in && !rxs) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (dec_tick) begin
                    state_next = vote ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (dec_tick && (bit_idx_reg == BIT_LAST)) begin
                    state_next = PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (dec_tick) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at the decision tick, not the bit end, lets a start
                // bit that follows immediately be caught on time.
                if (dec_tick && stop_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / control decode
    // -------------------------------------------------------------------------
    logic frame_start;
    logic shift_en;
    logic par_chk;
    logic stop_chk;
    logic commit;

    always_comb begin
        busy_out    = (state_reg != ST_IDLE);
        frame_start = (state_reg == ST_IDLE) && baud_tick_in && !rxs;
        shift_en    = (state_reg == ST_DATA) && dec_tick;
        par_chk     = (state_reg == ST_PARITY) && dec_tick;
        stop_chk    = (state_reg == ST_STOP) && dec_tick;
        commit      = (state_reg == ST_STOP) && dec_tick && stop_last;
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, bit indices, per-frame error flags
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            stop_idx_reg   <= 1'b0;
            par_flag_reg   <= 1'b0;
            frame_flag_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                bit_idx_reg    <= '0;
                stop_idx_reg   <= 1'b0;
                par_flag_reg   <= 1'b0;
                frame_flag_reg <= 1'b0;
            end
            if (shift_en) begin
                shift_reg <= shift_next;
                if (bit_idx_reg == BIT_LAST) begin
                    bit_idx_reg <= '0;
                end else begin
                    bit_idx_reg <= bit_idx_reg + BW'(1);
                end
            end
            if (par_chk) begin
                par_flag_reg <= (vote != par_expected);
            end
            if (stop_chk) begin
                stop_idx_reg <= ~stop_idx_reg;
                if (!vote) begin
                    frame_flag_reg <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output holder. The last stop vote is folded in directly since the frame
    // flag register would only see it one cycle after the commit.
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 perr_reg;
    logic                 ferr_reg;
    logic                 overrun_reg;
    logic                 accept;
    logic                 load;

    assign accept = valid_reg && rx_ready_in;
    assign load   = commit && (!valid_reg || rx_ready_in);

    always_ff @(posedge sysclk_in or posedge rst_in) begin
        if (rst_in) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= commit && valid_reg && !rx_ready_in;
            if (load) begin
                data_reg  <= shift_reg;
                perr_reg  <= par_flag_reg;
                ferr_reg  <= frame_flag_reg | ~vote;
                valid_reg <= 1'b1;
            end else if (accept) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data_out     = data_reg;
    assign rx_valid_out    = valid_reg;
    assign parity_err_out  = perr_reg;
    assign frame_err_out   = ferr_reg;
    assign overrun_err_out = overrun_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

    localparam int NI       = 6;
    localparam int TICK_DIV = 4;
    localparam int OS       = 16;
    localparam int MID      = OS / 2;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          rdy;
    logic [NI-1:0] rx_line;

    wire  [NI-1:0] valid_o;
    wire  [NI-1:0] perr_o;
    wire  [NI-1:0] ferr_o;
    wire  [NI-1:0] ovr_o;
    wire  [NI-1:0] busy_o;
    wire  [NI-1:0] rdy_o = {{(NI-1){1'b1}}, rdy};

    wire  [7:0] d0, d1, d2, d3;
    wire  [4:0] d4;
    wire  [8:0] d5;
    logic [8:0] data_o [NI];

    assign data_o[0] = {1'b0, d0};
    assign data_o[1] = {1'b0, d1};
    assign data_o[2] = {1'b0, d2};
    assign data_o[3] = {1'b0, d3};
    assign data_o[4] = {4'b0, d4};
    assign data_o[5] = d5;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;
    int   start_cyc;
    int   rise_cnt  [NI];
    int   rise_cyc  [NI];
    int   valid_cyc [NI];
    int   ovr_cnt   [NI];
    logic prev_v    [NI];

    always #5 clk = ~clk;

    // 8N1, 8E1, 8O1, 8N2, 5N1, 9N1
    uart_rx_os #(.OVERSAMPLING(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
        .sysclk_in(clk), .rst_in(rst), .baud_tick_in(tick), .rx_serial_in(rx_line[0]),
        .rx_data_out(d0), .rx_valid_out(valid_o[0]), .rx_ready_in(rdy),
        .parity_err_out(perr_o[0]), .frame_err_out(ferr_o[0]),
        .overrun_err_out(ovr_o[0]), .busy_out(busy_o[0]));
    uart_rx_os #(.OVERSAMPLING(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .sysclk_in(clk), .rst_in(rst), .baud_tick_in(tick), .rx_serial_in(rx_line[1]),
        .rx_data_out(d1), .rx_valid_out(valid_o[1]), .rx_ready_in(1'b1),
        .parity_err_out(perr_o[1]), .frame_err_out(ferr_o[1]),
        .overrun_err_out(ovr_o[1]), .busy_out(busy_o[1]));
    uart_rx_os #(.OVERSAMPLING(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .sysclk_in(clk), .rst_in(rst), .baud_tick_in(tick), .rx_serial_in(rx_line[2]),
        .rx_data_out(d2), .rx_valid_out(valid_o[2]), .rx_ready_in(1'b1),
        .parity_err_out(perr_o[2]), .frame_err_out(ferr_o[2]),
        .overrun_err_out(ovr_o[2]), .busy_out(busy_o[2]));
    uart_rx_os #(.OVERSAMPLING(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
        .sysclk_in(clk), .rst_in(rst), .baud_tick_in(tick), .rx_serial_in(rx_line[3]),
        .rx_data_out(d3), .rx_valid_out(valid_o[3]), .rx_ready_in(1'b1),
        .parity_err_out(perr_o[3]), .frame_err_out(ferr_o[3]),
        .overrun_err_out(ovr_o[3]), .busy_out(busy_o[3]));
    uart_rx_os #(.OVERSAMPLING(OS), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d5 (
        .sysclk_in(clk), .rst_in(rst), .baud_tick_in(tick), .rx_serial_in(rx_line[4]),
        .rx_data_out(d4), .rx_valid_out(valid_o[4]), .rx_ready_in(1'b1),
        .parity_err_out(perr_o[4]), .frame_err_out(ferr_o[4]),
        .overrun_err_out(ovr_o[4]), .busy_out(busy_o[4]));
    uart_rx_os #(.OVERSAMPLING(OS), .DATA_BITS(9), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d9 (
        .sysclk_in(clk), .rst_in(rst), .baud_tick_in(tick), .rx_serial_in(rx_line[5]),
        .rx_data_out(d5), .rx_valid_out(valid_o[5]), .rx_ready_in(1'b1),
        .parity_err_out(perr_o[5]), .frame_err_out(ferr_o[5]),
        .overrun_err_out(ovr_o[5]), .busy_out(busy_o[5]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Baud tick: one cycle high every TICK_DIV cycles, changed on negedges.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            rise_cnt[i] = 0; rise_cyc[i] = 0; valid_cyc[i] = 0; ovr_cnt[i] = 0; prev_v[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (valid_o[i] && !prev_v[i]) begin
                    rise_cnt[i]++;
                    rise_cyc[i] = cyc;
                end
                prev_v[i] = valid_o[i];
                if (valid_o[i]) valid_cyc[i]++;
                if (ovr_o[i]) ovr_cnt[i]++;
                if (valid_o[i] && rdy_o[i]) begin
                    $display("rx inst%0d data=0x%0h perr=%0b ferr=%0b", i, data_o[i], perr_o[i], ferr_o[i]);
                    check_eq("sb_has_entry", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check_eq("sb_inst", i, e.inst);
                        check_eq("sb_data", 32'(data_o[i]), 32'(e.data));
                        check_eq("sb_perr", 32'(perr_o[i]), 32'(e.perr));
                        check_eq("sb_ferr", 32'(ferr_o[i]), 32'(e.ferr));
                    end
                end
            end
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!tick);
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    // Holds one bit for OS ticks; optionally inverts it for the single tick
    // that lands on the centre sample (count MID).
    task automatic drive_bit(input int inst, input logic v, input bit spike);
        #1 rx_line[inst] = v;
        if (spike) begin
            idle_ticks(MID + 1);
            #1 rx_line[inst] = ~v;
            wait_tick();
            #1 rx_line[inst] = v;
            idle_ticks(OS - MID - 2);
        end else begin
            idle_ticks(OS);
        end
    endtask

    // Edge offset (from the start-bit drive edge) of the last stop decision.
    function automatic int last_dec_off(input int nbits, input int par_en, input int nstop);
        return TICK_DIV * (OS * (nbits + par_en + nstop) + MID + 3);
    endfunction

    // par_mode: 0 none, 1 even, 2 odd
    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input int par_mode, input bit par_flip, input int nstop,
                              input bit stop2_low, input int spike_bit, input bit expect_word);
        logic [8:0] mask;
        logic [8:0] md;
        logic       par;
        exp_t       e;
        mask = 9'((32'd1 << nbits) - 1);
        md   = data & mask;
        par  = (^md) ^ (par_mode == 2) ^ par_flip;
        wait_tick();
        start_cyc = cyc;
        if (expect_word) begin
            e.inst = inst;
            e.data = md;
            e.perr = par_flip && (par_mode != 0);
            e.ferr = stop2_low && (nstop == 2);
            exp_q.push_back(e);
        end
        drive_bit(inst, 1'b0, 1'b0);
        for (int b = 0; b < nbits; b++) drive_bit(inst, md[b], b == spike_bit);
        if (par_mode != 0) drive_bit(inst, par, 1'b0);
        drive_bit(inst, 1'b1, 1'b0);
        if (nstop == 2) drive_bit(inst, ~stop2_low, 1'b0);
        #1 rx_line[inst] = 1'b1;
    endtask

    initial begin
        int r0;
        int v0;
        rst     = 1'b1;
        rdy     = 1'b1;
        rx_line = '1;
        start_cyc = 0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_eq("reset_valid", 32'(valid_o[i]), 0);
            check_eq("reset_busy", 32'(busy_o[i]), 0);
            check_eq("reset_data", 32'(data_o[i]), 0);
            check_eq("reset_flags", 32'({perr_o[i], ferr_o[i], ovr_o[i]}), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_ticks(4);

        // 1: 8N1 basic frame, latency and single-cycle valid
        v0 = valid_cyc[0];
        send_frame(0, 9'h0A5, 8, 0, 0, 1, 0, -1, 1);
        check_eq("t1_latency", 32'(rise_cyc[0] - start_cyc), 32'(last_dec_off(8, 0, 1) + 1));
        check_eq("t1_valid_cycles", 32'(valid_cyc[0] - v0), 1);
        check_eq("t1_busy_after", 32'(busy_o[0]), 0);
        check_eq("t1_valid_after", 32'(valid_o[0]), 0);

        // 2: parity even/odd, wrong and right
        send_frame(1, 9'h03C, 8, 1, 1, 1, 0, -1, 1);
        send_frame(1, 9'h03C, 8, 1, 0, 1, 0, -1, 1);
        send_frame(2, 9'h03C, 8, 2, 1, 1, 0, -1, 1);
        send_frame(2, 9'h03C, 8, 2, 0, 1, 0, -1, 1);

        // 3: short low glitch aborts in START; centre spike is outvoted
        r0 = rise_cnt[0];
        wait_tick();
        #1 rx_line[0] = 1'b0;
        idle_ticks(2);
        #1;
        check_eq("t3_busy_in_start", 32'(busy_o[0]), 1);
        idle_ticks(2);
        #1 rx_line[0] = 1'b1;
        idle_ticks(20);
        #1;
        check_eq("t3_busy_after_glitch", 32'(busy_o[0]), 0);
        check_eq("t3_no_word", 32'(rise_cnt[0] - r0), 0);
        send_frame(0, 9'h0C3, 8, 0, 0, 1, 0, 3, 1);
        send_frame(0, 9'h0C3, 8, 0, 0, 1, 0, 0, 1);

        // 4: two stop bits, second one low
        send_frame(3, 9'h07E, 8, 0, 0, 2, 0, -1, 1);
        send_frame(3, 9'h081, 8, 0, 0, 2, 1, -1, 1);
        idle_ticks(24);

        // 5: overrun, then accept coinciding with a commit
        r0  = rise_cnt[0];
        rdy = 1'b0;
        send_frame(0, 9'h011, 8, 0, 0, 1, 0, -1, 1);
        send_frame(0, 9'h022, 8, 0, 0, 1, 0, -1, 0);
        #1;
        check_eq("t5_held_data", 32'(data_o[0]), 32'h11);
        check_eq("t5_held_valid", 32'(valid_o[0]), 1);
        check_eq("t5_overrun_once", 32'(ovr_cnt[0]), 1);
        start_cyc = -1;
        fork
            send_frame(0, 9'h033, 8, 0, 0, 1, 0, -1, 1);
            begin
                while (start_cyc < 0) @(posedge clk);
                while (cyc != start_cyc + last_dec_off(8, 0, 1) - 1) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        check_eq("t5_no_new_overrun", 32'(ovr_cnt[0]), 1);
        check_eq("t5_valid_never_dropped", 32'(rise_cnt[0] - r0), 1);

        // 6: reset in the middle of data bit 4, then a clean frame
        start_cyc = -1;
        fork
            send_frame(0, 9'h0FF, 8, 0, 0, 1, 0, -1, 0);
            begin
                while (start_cyc < 0) @(posedge clk);
                while (cyc != start_cyc + OS * TICK_DIV * 5 + OS * TICK_DIV / 2) @(posedge clk);
                check_eq("t6_busy_before_rst", 32'(busy_o[0]), 1);
                #3 rst = 1'b1;
                #1;
                check_eq("t6_rst_busy", 32'(busy_o[0]), 0);
                check_eq("t6_rst_valid", 32'(valid_o[0]), 0);
                check_eq("t6_rst_data", 32'(data_o[0]), 0);
                check_eq("t6_rst_flags", 32'({perr_o[0], ferr_o[0], ovr_o[0]}), 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        idle_ticks(4);
        send_frame(0, 9'h05A, 8, 0, 0, 1, 0, -1, 1);
        send_frame(4, 9'h015, 5, 0, 0, 1, 0, -1, 1);
        send_frame(5, 9'h1AB, 9, 0, 0, 1, 0, -1, 1);

        idle_ticks(8);
        check_eq("sb_drained", 32'(exp_q.size()), 0);
        for (int i = 1; i < NI; i++) check_eq("no_overrun_other", 32'(ovr_cnt[i]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
